// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
// Holds the FSM state encoding and the shared-counter width calculation.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAULT
  } pll_state_t;

  // The counter only ever holds (cycles - 1), so $clog2 of the largest interval is enough.
  function automatic int unsigned counterWidth(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer for bringing asynchronous levels into a clock domain.
// Both stages clear to 0 on synchronous reset.
module sync_2ff (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings the board PLL from power-up to a stable clock: reset pulse, lock wait with retries,
// lock stabilisation, then releases the system reset and re-sequences on lock loss.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_reset_n,
  output logic       sys_reset,
  output logic       ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int unsigned CNT_W = counterWidth(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CNT_W-1:0] RESET_LOAD   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

  logic             w_lockSync;
  pll_state_t       r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_pllResetN;
  logic             r_sysReset;
  logic             r_ready;
  logic             r_fault;
  logic [1:0]       r_retryCount;
  logic [7:0]       r_lossCount;

  sync_2ff u_lockSync (
    .i_clock (clock_in),
    .i_reset (reset),
    .i_d     (pll_locked),
    .o_q     (w_lockSync)
  );

  // Counter holds remaining cycles minus one; zero means the current interval ends this edge.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      r_state      <= ST_RESET_PLL;
      r_count      <= RESET_LOAD;
      r_pllResetN  <= 1'b0;
      r_sysReset   <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_retryCount <= 2'd0;
      r_lossCount  <= 8'd0;
    end else if (restart) begin
      r_state      <= ST_RESET_PLL;
      r_count      <= RESET_LOAD;
      r_pllResetN  <= 1'b0;
      r_sysReset   <= 1'b1;
      r_ready      <= 1'b0;
      r_fault      <= 1'b0;
      r_retryCount <= 2'd0;
    end else begin
      case (r_state)
        ST_RESET_PLL: begin
          if (r_count == '0) begin
            r_state     <= ST_WAIT_LOCK;
            r_count     <= TIMEOUT_LOAD;
            r_pllResetN <= 1'b1;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        // Lock is checked before expiry so a lock on the last cycle still counts.
        ST_WAIT_LOCK: begin
          if (w_lockSync) begin
            r_state <= ST_STABILIZE;
            r_count <= STABLE_LOAD;
          end else if (r_count == '0) begin
            r_pllResetN <= 1'b0;
            if (r_retryCount == RETRY_LIMIT) begin
              r_state <= ST_FAULT;
              r_count <= '0;
              r_fault <= 1'b1;
            end else begin
              r_state      <= ST_RESET_PLL;
              r_count      <= RESET_LOAD;
              r_retryCount <= (r_retryCount == 2'd3) ? 2'd3 : r_retryCount + 2'd1;
            end
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        ST_STABILIZE: begin
          if (!w_lockSync) begin
            r_state <= ST_WAIT_LOCK;
            r_count <= TIMEOUT_LOAD;
          end else if (r_count == '0) begin
            r_state      <= ST_RUN;
            r_count      <= '0;
            r_sysReset   <= 1'b0;
            r_ready      <= 1'b1;
            r_retryCount <= 2'd0;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_lockSync) begin
            r_state     <= ST_RESET_PLL;
            r_count     <= RESET_LOAD;
            r_pllResetN <= 1'b0;
            r_sysReset  <= 1'b1;
            r_ready     <= 1'b0;
            if (r_lossCount != 8'hFF) r_lossCount <= r_lossCount + 8'd1;
          end
        end
        ST_FAULT: begin
          r_state <= ST_FAULT;
        end
        default: begin
          r_state     <= ST_RESET_PLL;
          r_count     <= RESET_LOAD;
          r_pllResetN <= 1'b0;
          r_sysReset  <= 1'b1;
          r_ready     <= 1'b0;
          r_fault     <= 1'b0;
        end
      endcase
    end
  end

  assign pll_reset_n = r_pllResetN;
  assign sys_reset   = r_sysReset;
  assign ready       = r_ready;
  assign fault       = r_fault;
  assign retry_count = r_retryCount;
  assign loss_count  = r_lossCount;

endmodule
